bcd_display_scanner: RTL
========================

Name: bcd_display_scanner

Overview:
Downstream consumer of the 32-bit binary-to-BCD converter. Captures the converter's 11 BCD digits (plus a sign flag) through a valid/ready handshake and double-buffers them. Applies leading-zero blanking and sign placement, then time-multiplexes the digits onto a common-anode 7-segment display bank with a programmable refresh rate.

Parameters:
NUM_DIGITS, 11, number of BCD digits and display positions (digit 0 = least significant)
REFRESH_DIV, 50000, clock cycles each digit stays lit (minimum 2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
load  input  1  bcd_in/negative valid; a transfer occurs when load && ready
bcd_in  input  4*NUM_DIGITS  packed BCD; digit k at [4k+3:4k]
negative  input  1  value is negative; display a minus sign
ready  output  1  pending buffer empty; block can accept a load
seg_out  output  7  {g,f,e,d,c,b,a}; active-low
dig_en  output  NUM_DIGITS  one-hot active-low digit enable
frame_done  output  1  one-cycle pulse when the last digit slot ends

Behaviour:
- Clock/reset: single clock domain on clk. Reset is synchronous and active-low.
- Reset values:
  - seg_out = 7'h7F, dig_en = all 1s, ready = 1, frame_done = 0
  - prescaler = 0, digit index = 0
  - FSM = BLANK; display and pending registers cleared
- Prescaler: counts 0..REFRESH_DIV-1. At terminal count it wraps to 0 and the index advances 0..NUM_DIGITS-1, wrapping to 0.
- frame_done pulses on the cycle the index wraps from NUM_DIGITS-1 to 0.
- Handshake:
  - A transfer on load && ready writes the pending buffer (digits + sign) and drops ready on the next cycle.
  - The pending buffer is copied into the display register at a frame boundary, i.e. the same cycle frame_done pulses. ready rises the following cycle.
  - load while ready=0 is ignored; the data is not captured.
- FSM:
  - BLANK: no valid data; outputs are off but the scan still runs. A transfer moves to PENDING.
  - PENDING: holds the buffer until the frame boundary, then copies it and moves to SCAN.
  - SCAN: shows the display register. A transfer moves to PENDING, and the old value stays displayed until the boundary.
- Output pipeline:
  - seg_out and dig_en are registered, with 1-cycle latency after an index change.
  - Exactly one dig_en bit is low in PENDING and SCAN.
  - In BLANK, dig_en = all 1s.
- Blanking:
  - msd = highest index with a nonzero digit; msd = 0 if all digits are zero.
  - Digits above msd are blanked (7'h7F). Digit 0 is never blanked.
- Sign:
  - If negative, position msd+1 shows minus (7'h3F).
  - If msd = NUM_DIGITS-1, the sign is dropped; it never wraps.
  - negative with a value of 0 shows "-0".
- Segment map (active-low):
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19
  - 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 10
  - Any nibble > 9 shows E = 06. It counts as nonzero for msd.
- Reset mid-operation: pending data is discarded, the display blanks, and ready = 1 on the cycle after reset deasserts.

Optional Feature:
DISPLAY_LAMP_TEST_EN.
- With the macro defined: adds input lamp_test (1). While it is high, seg_out = 7'h00 on every scanned digit, bypassing blanking and the BLANK state (dig_en still scans). Handshake and buffers are unaffected.
- Without the macro: the port and logic are absent.

Decomposition:
- Package bcd_display_pkg holds:
  - typedef state_t {BLANK, PENDING, SCAN}
  - constants SEG_BLANK, SEG_MINUS, SEG_ERR
  - the 16-entry segment lookup function
- One sub-module, bcd_to_7seg: combinational nibble plus blank/minus control in, 7-bit pattern out. It is instantiated once, after the digit mux.

Test Plan:
All scenarios use REFRESH_DIV=4.
1. Reset, no load → dig_en = 11'h7FF and seg_out = 7'h7F for 3 frames; ready = 1; frame_done every 44 cycles.
2. Load 0x000_0000_1234 (digits 4,3,2,1), negative=0 → after the next frame_done, digit0 = 19, digit1 = 30, digit2 = 24, digit3 = 79; digits 4-10 = 7F.
3. Load 4294967295, negative=1 → digits 0-9 show the value; digit10 = 3F.
4. Load A, then load B on the next cycle → second load ignored (ready = 0). A is displayed after the boundary; ready returns 1 one cycle after frame_done.
5. Assert reset mid-frame while PENDING → next cycle: all outputs at reset values, ready = 1, nothing displayed.
6. Load bcd_in with digit2 = 4'hC, all else 0 → digit2 = 06, digit1 = 40, digit0 = 40, digits 3-10 blank. With DISPLAY_LAMP_TEST_EN defined and lamp_test = 1, every digit shows 00.

Source files
------------

// File: rtl/bcd_display_pkg.sv
// rtl/bcd_display_pkg.sv - shared types, segment constants and BCD segment lookup
//
// Purpose: FSM state type, active-low segment patterns ({g,f,e,d,c,b,a}) and
// the 16-entry nibble-to-segment lookup used by the display scanner.
package bcd_display_pkg;

    typedef enum logic [1:0] {
        BLANK   = 2'd0,
        PENDING = 2'd1,
        SCAN    = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_ERR   = 7'h06;

    // Non-decimal nibbles render as "E" so corrupt input is visible.
    function automatic logic [6:0] seg_lookup(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_ERR;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_display_to_7seg.sv
// rtl/bcd_display_to_7seg.sv - combinational nibble to active-low 7-segment pattern
//
// Purpose: converts one BCD nibble into a segment pattern, with overrides for
// the minus sign and leading-zero blanking.
// Ports:
//   nibble - BCD digit selected by the scan mux
//   blank  - force all segments off
//   minus  - show the minus sign (takes priority over blank)
//   seg    - {g,f,e,d,c,b,a}, active-low
module bcd_to_7seg
    import bcd_display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    input  logic       minus,
    output logic [6:0] seg
);

    // The sign sits one position above the most significant digit, which is
    // also a blanked position, so minus must win over blank.
    always_comb begin
        seg = seg_lookup(nibble);
        if (minus) begin
            seg = SEG_MINUS;
        end else if (blank) begin
            seg = SEG_BLANK;
        end
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - double-buffered, multiplexed BCD 7-segment scanner
//
// Purpose: accepts NUM_DIGITS BCD digits plus a sign through a load/ready
// handshake, holds them in a pending buffer until a frame boundary, then scans
// them with leading-zero blanking and sign placement onto a common-anode bank.
// Optional feature macro: DISPLAY_LAMP_TEST_EN (adds the lamp_test input).
// Ports:
//   clk        - system clock
//   reset      - synchronous, active-low reset
//   load       - bcd_in/negative valid; transfer on load && ready
//   bcd_in     - packed BCD, digit k at [4k+3:4k]
//   negative   - show a minus sign
//   lamp_test  - (macro only) all segments on for every scanned digit
//   ready      - pending buffer empty
//   seg_out    - {g,f,e,d,c,b,a}, active-low, registered
//   dig_en     - one-hot active-low digit enable, registered
//   frame_done - one-cycle pulse when the last digit slot ends
module bcd_display_scanner
    import bcd_display_pkg::*;
#(
    parameter int NUM_DIGITS  = 11,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    negative,
`ifdef DISPLAY_LAMP_TEST_EN
    input  logic                    lamp_test,
`endif
    output logic                    ready,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_done
);

    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [PRE_W-1:0]        presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    state_t                  state_q, state_d;
    logic [4*NUM_DIGITS-1:0] pend_digits_q, pend_digits_d;
    logic                    pend_neg_q, pend_neg_d;
    logic [4*NUM_DIGITS-1:0] disp_digits_q, disp_digits_d;
    logic                    disp_neg_q, disp_neg_d;
    logic                    ready_q, ready_d;
    logic                    frame_done_q, frame_done_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   dig_en_q, dig_en_d;

    logic                    tick;
    logic                    wrap;
    logic                    xfer;
    logic [IDX_W-1:0]        msd;
    logic [3:0]              cur_nib;
    logic                    blank_c;
    logic                    minus_c;
    logic [6:0]              seg_pat;

    // Most significant nonzero digit of the displayed value; digit 0 is the
    // floor so a zero value still shows a single "0".
    always_comb begin
        msd = '0;
        for (int k = 1; k < NUM_DIGITS; k++) begin
            if (disp_digits_q[4*k +: 4] != 4'd0) begin
                msd = IDX_W'(k);
            end
        end
    end

    assign cur_nib = disp_digits_q[4*idx_q +: 4];
    assign blank_c = (idx_q > msd);
    // With msd at the top position there is no slot left for the sign.
    assign minus_c = disp_neg_q
                   && (msd != IDX_W'(NUM_DIGITS-1))
                   && ({1'b0, idx_q} == ({1'b0, msd} + 1'b1));

    bcd_to_7seg u_seg (
        .nibble (cur_nib),
        .blank  (blank_c),
        .minus  (minus_c),
        .seg    (seg_pat)
    );

    always_comb begin
        tick = (presc_q == PRE_W'(REFRESH_DIV-1));
        wrap = tick && (idx_q == IDX_W'(NUM_DIGITS-1));
        xfer = load && ready_q;

        presc_d       = tick ? '0 : presc_q + 1'b1;
        idx_d         = idx_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end
        frame_done_d  = wrap;

        state_d       = state_q;
        pend_digits_d = pend_digits_q;
        pend_neg_d    = pend_neg_q;
        disp_digits_d = disp_digits_q;
        disp_neg_d    = disp_neg_q;

        if (xfer) begin
            pend_digits_d = bcd_in;
            pend_neg_d    = negative;
        end

        case (state_q)
            BLANK: begin
                if (xfer) state_d = PENDING;
            end
            PENDING: begin
                if (wrap) begin
                    disp_digits_d = pend_digits_q;
                    disp_neg_d    = pend_neg_q;
                    state_d       = SCAN;
                end
            end
            SCAN: begin
                if (xfer) state_d = PENDING;
            end
            default: state_d = BLANK;
        endcase

        // ready reopens the cycle after the frame_done pulse that emptied the
        // pending buffer, not in the same cycle.
        ready_d = ready_q;
        if (xfer) begin
            ready_d = 1'b0;
        end else if (frame_done_q && (state_q == SCAN)) begin
            ready_d = 1'b1;
        end

        // Outputs follow idx_q one cycle later; the display register copy at
        // a boundary takes effect from digit 0 of the new frame.
        if (state_q == BLANK) begin
            dig_en_d = '1;
            seg_d    = SEG_BLANK;
        end else begin
            dig_en_d = ~(NUM_DIGITS'(1) << idx_q);
            seg_d    = seg_pat;
        end
`ifdef DISPLAY_LAMP_TEST_EN
        if (lamp_test) begin
            dig_en_d = ~(NUM_DIGITS'(1) << idx_q);
            seg_d    = 7'h00;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            presc_q       <= '0;
            idx_q         <= '0;
            state_q       <= BLANK;
            pend_digits_q <= '0;
            pend_neg_q    <= 1'b0;
            disp_digits_q <= '0;
            disp_neg_q    <= 1'b0;
            ready_q       <= 1'b1;
            frame_done_q  <= 1'b0;
            seg_q         <= SEG_BLANK;
            dig_en_q      <= '1;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            state_q       <= state_d;
            pend_digits_q <= pend_digits_d;
            pend_neg_q    <= pend_neg_d;
            disp_digits_q <= disp_digits_d;
            disp_neg_q    <= disp_neg_d;
            ready_q       <= ready_d;
            frame_done_q  <= frame_done_d;
            seg_q         <= seg_d;
            dig_en_q      <= dig_en_d;
        end
    end

    assign ready      = ready_q;
    assign seg_out    = seg_q;
    assign dig_en     = dig_en_q;
    assign frame_done = frame_done_q;

endmodule
